// File: rtl/audio_ctrl_pkg.sv
// rtl/audio_ctrl_pkg.sv - shared types and constants for the flash audio player
package audio_ctrl_pkg;

    localparam int ADDR_W = 23;
    localparam int HOLD_W = 16;

    localparam logic [5:0] FLASH_BURSTCOUNT  = 6'd1;
    localparam logic [3:0] FLASH_BYTEENABLE  = 4'hF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_REQ  = 3'd1,
        WAIT_DATA = 3'd2,
        PLAY_A    = 3'd3,
        PLAY_B    = 3'd4,
        NEXT_ADDR = 3'd5
    } state_t;

endpackage

// File: rtl/sample_hold_timer.sv
// rtl/sample_hold_timer.sv - counts the clock cycles one audio sample is held
module sample_hold_timer
    import audio_ctrl_pkg::*;
#(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic done
);

    localparam logic [HOLD_W-1:0] TERMINAL = HOLD_W'(CYCLES - 1);

    logic [HOLD_W-1:0] count;

    assign done = (count == TERMINAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear || done) begin
            count <= '0;
        end else begin
            count <= count + HOLD_W'(1);
        end
    end

endmodule

// File: rtl/audio_controller.sv
// rtl/audio_controller.sv - streams 8-bit samples from flash words to audio_output
module audio_controller
    import audio_ctrl_pkg::*;
#(
    parameter int unsigned        SAMPLE_CYCLES = 4,
    parameter logic [ADDR_W-1:0]  MAX_ADDR      = 23'h7FFFF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              flash_mem_read,
    output logic              flash_mem_write,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [31:0]       flash_mem_writedata,
    output logic [5:0]        flash_mem_burstcount,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [7:0]        audio_output
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] address;
    logic [7:0]        sample_b;
    logic              load_a;
    logic              load_b;
    logic              hold_clear;
    logic              hold_done;
    logic              unused_readdata;

    assign flash_mem_write      = 1'b0;
    assign flash_mem_byteenable = FLASH_BYTEENABLE;
    assign flash_mem_writedata  = 32'd0;
    assign flash_mem_burstcount = FLASH_BURSTCOUNT;
    assign flash_mem_address    = address;
    assign unused_readdata      = ^flash_mem_readdata[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read data is only honoured in WAIT_DATA, so stray or late valids cannot disturb playback.
    always_comb begin
        state_next     = state;
        flash_mem_read = 1'b0;
        load_a         = 1'b0;
        load_b         = 1'b0;
        case (state)
            IDLE: begin
                state_next = READ_REQ;
            end
            READ_REQ: begin
                flash_mem_read = 1'b1;
                if (!flash_mem_waitrequest) begin
                    state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    load_a     = 1'b1;
                    state_next = PLAY_A;
                end
            end
            PLAY_A: begin
                if (hold_done) begin
                    load_b     = 1'b1;
                    state_next = PLAY_B;
                end
            end
            PLAY_B: begin
                if (hold_done) begin
                    state_next = NEXT_ADDR;
                end
            end
            NEXT_ADDR: begin
                state_next = READ_REQ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign hold_clear = load_a || load_b || !((state == PLAY_A) || (state == PLAY_B));

    sample_hold_timer #(
        .CYCLES (SAMPLE_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (hold_clear),
        .done  (hold_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            address      <= '0;
            audio_output <= 8'h00;
            sample_b     <= 8'h00;
        end else begin
            if (load_a) begin
                audio_output <= flash_mem_readdata[7:0];
                sample_b     <= flash_mem_readdata[15:8];
            end else if (load_b) begin
                audio_output <= sample_b;
            end
            if (state == NEXT_ADDR) begin
                address <= (address == MAX_ADDR) ? '0 : address + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_audio_controller.sv
// tb/tb_audio_controller.sv - directed vector bench for audio_controller
module tb_audio_controller;

    logic        clk;
    logic        rst;
    logic        flash_mem_read;
    logic        flash_mem_write;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic [31:0] flash_mem_writedata;
    logic [5:0]  flash_mem_burstcount;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic [7:0]  audio_output;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rdv;
        logic [31:0] data;
        logic        read;
        logic [22:0] addr;
        logic [7:0]  audio;
    } vec_t;

    vec_t vecs[$];

    audio_controller #(
        .SAMPLE_CYCLES (4),
        .MAX_ADDR      (23'd3)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_write         (flash_mem_write),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_writedata     (flash_mem_writedata),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .audio_output            (audio_output)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic wr, input logic rdv, input logic [31:0] data);
        rst                     = r;
        flash_mem_waitrequest   = wr;
        flash_mem_readdatavalid = rdv;
        flash_mem_readdata      = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic read, input logic [22:0] addr,
                              input logic [7:0] audio);
        check({tag, " read"}, {31'd0, flash_mem_read}, {31'd0, read});
        check({tag, " address"}, {9'd0, flash_mem_address}, {9'd0, addr});
        check({tag, " audio"}, {24'd0, audio_output}, {24'd0, audio});
        check({tag, " ties"}, {21'd0, flash_mem_write, flash_mem_byteenable, flash_mem_burstcount},
              {21'd0, 1'b0, 4'hF, 6'd1});
        check({tag, " writedata"}, flash_mem_writedata, 32'd0);
    endtask

    task automatic add(input logic r, input logic wr, input logic rdv, input logic [31:0] data,
                       input logic read, input logic [22:0] addr, input logic [7:0] audio);
        vecs.push_back('{r, wr, rdv, data, read, addr, audio});
    endtask

    // Starts in READ_REQ at addr; leaves the DUT in READ_REQ at the following address.
    task automatic play_word(input string tag, input logic [31:0] data, input logic [22:0] addr,
                             input logic [7:0] prev);
        drive(0, 0, 0, 0);
        expect_out({tag, " req"}, 1'b1, addr, prev);
        tick();
        drive(0, 0, 1, data);
        expect_out({tag, " wait"}, 1'b0, addr, prev);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            expect_out({tag, " play_a"}, 1'b0, addr, data[7:0]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            expect_out({tag, " play_b"}, 1'b0, addr, data[15:8]);
            tick();
        end
        expect_out({tag, " next"}, 1'b0, addr, data[15:8]);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1, 0, 0, 0);
        tick();

        // Reset, first two words, then a stalled request at address 2.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 32'd0, 0, 23'd0, 8'h00);
        add(0, 0, 0, 32'd0,        0, 23'd0, 8'h00);
        add(0, 0, 0, 32'd0,        1, 23'd0, 8'h00);
        add(0, 0, 0, 32'd0,        0, 23'd0, 8'h00);
        add(0, 0, 1, 32'h0000ABCD, 0, 23'd0, 8'h00);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 32'd0, 0, 23'd0, 8'hCD);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 32'd0, 0, 23'd0, 8'hAB);
        add(0, 0, 0, 32'd0,        0, 23'd0, 8'hAB);
        add(0, 0, 0, 32'd0,        1, 23'd1, 8'hAB);
        add(0, 0, 0, 32'd0,        0, 23'd1, 8'hAB);
        add(0, 0, 1, 32'h00001234, 0, 23'd1, 8'hAB);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 32'd0, 0, 23'd1, 8'h34);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 32'd0, 0, 23'd1, 8'h12);
        add(0, 0, 0, 32'd0,        0, 23'd1, 8'h12);
        add(0, 1, 0, 32'd0,        1, 23'd2, 8'h12);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].rdv, vecs[i].data);
            expect_out($sformatf("vec%0d", i), vecs[i].read, vecs[i].addr, vecs[i].audio);
            tick();
        end

        // Waitrequest stall continues, then acceptance with a coincident valid that must be ignored.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0);
            expect_out("stall", 1'b1, 23'd2, 8'h12);
            tick();
        end
        drive(0, 0, 1, 32'h00005555);
        expect_out("accept", 1'b1, 23'd2, 8'h12);
        tick();
        drive(0, 0, 0, 0);
        expect_out("wait0", 1'b0, 23'd2, 8'h12);
        tick();
        expect_out("wait1", 1'b0, 23'd2, 8'h12);
        drive(0, 0, 1, 32'h00007788);
        tick();

        // Spurious valid in PLAY_A must not alter output or hold timing.
        drive(0, 0, 0, 0);
        expect_out("pa0", 1'b0, 23'd2, 8'h88);
        tick();
        drive(0, 0, 1, 32'h00009999);
        expect_out("pa1", 1'b0, 23'd2, 8'h88);
        tick();
        drive(0, 0, 0, 0);
        expect_out("pa2", 1'b0, 23'd2, 8'h88);
        tick();
        expect_out("pa3", 1'b0, 23'd2, 8'h88);
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_out("pb", 1'b0, 23'd2, 8'h77);
            tick();
        end
        expect_out("next2", 1'b0, 23'd2, 8'h77);
        tick();

        // Address 3 is MAX_ADDR for this instance, so the next request wraps to 0.
        play_word("w3", 32'hFFFF2211, 23'd3, 8'h77);
        play_word("w0", 32'h00004433, 23'd0, 8'h22);

        // Reset during PLAY_B, followed by a late valid that must be ignored.
        drive(0, 0, 0, 0);
        expect_out("r_req", 1'b1, 23'd1, 8'h44);
        tick();
        drive(0, 0, 1, 32'h00006655);
        expect_out("r_wait", 1'b0, 23'd1, 8'h44);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            expect_out("r_pa", 1'b0, 23'd1, 8'h55);
            tick();
        end
        expect_out("r_pb0", 1'b0, 23'd1, 8'h66);
        tick();
        drive(1, 0, 0, 0);
        expect_out("r_pb1", 1'b0, 23'd1, 8'h66);
        tick();
        drive(0, 1, 1, 32'h0000FFEE);
        expect_out("r_idle", 1'b0, 23'd0, 8'h00);
        tick();
        drive(0, 1, 0, 0);
        expect_out("r_restart", 1'b1, 23'd0, 8'h00);
        tick();
        drive(0, 1, 1, 32'h0000FFEE);
        expect_out("r_stall", 1'b1, 23'd0, 8'h00);
        tick();
        drive(0, 0, 0, 0);
        expect_out("r_accept", 1'b1, 23'd0, 8'h00);
        tick();
        expect_out("r_wait2", 1'b0, 23'd0, 8'h00);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
